// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser:
// reference op codes and sweep FSM states.
package gate_exerciser_pkg;

  localparam int OP_OR  = 0;
  localparam int OP_AND = 1;
  localparam int OP_XOR = 2;
  localparam int OP_NOR = 3;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/gate_exerciser_ref.sv
// Combinational reference model of a 2-input
// bitwise gate, selected by OP.
module gate_ref
  import gate_exerciser_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int OP    = OP_OR
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the reference function for OP
  always_comb begin
    y = a | b;
    unique case (1'b1)
      (OP == OP_OR):  y = a | b;
      (OP == OP_AND): y = a & b;
      (OP == OP_XOR): y = a ^ b;
      (OP == OP_NOR): y = ~(a | b);
      default:        y = a | b;
    endcase
  end

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps every a/b operand pair into a gate under
// test and checks c against the reference model.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int OP     = OP_OR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec
);

  localparam int VW = 2 * WIDTH;
  localparam logic [3:0] SET = 4'(SETTLE);

  state_t           state;
  logic [VW-1:0]    vec;
  logic [3:0]       wcnt;
  logic [WIDTH-1:0] expd;
  logic [WIDTH-1:0] ref_y;

  gate_ref #(
    .WIDTH (WIDTH),
    .OP    (OP)
  ) u_ref (
    .a (vec[WIDTH-1:0]),
    .b (vec[VW-1:WIDTH]),
    .y (ref_y)
  );

  // Sweep FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      wcnt       <= '0;
      expd       <= '0;
      a          <= '0;
      b          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state <= IDLE;
        a     <= '0;
        b     <= '0;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              state      <= DRIVE;
              vec        <= '0;
              err_count  <= '0;
              fail_valid <= 1'b0;
              pass       <= 1'b0;
              busy       <= 1'b1;
            end
          end
          DRIVE: begin
            a     <= vec[WIDTH-1:0];
            b     <= vec[VW-1:WIDTH];
            expd  <= ref_y;
            wcnt  <= SET;
            state <= WAIT;
          end
          WAIT: begin
            wcnt <= wcnt - 4'd1;
            if (wcnt <= 4'd1) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (c != expd) begin
              err_count <= err_count + 1'b1;
              if (!fail_valid) begin
                fail_vec   <= {b, a};
                fail_valid <= 1'b1;
              end
            end
            if (&vec) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              vec   <= vec + 1'b1;
              state <= DRIVE;
            end
          end
          DONE: begin
            pass  <= (err_count == '0);
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
